id_ex_stage: RTL

//  ID/EX pipeline register of the 5-stage MIPS pipeline, with load-use hazard detection.

---
 rtl/id_ex_stage_if.sv | 66 ++++++
 rtl/id_ex_stage.sv | 106 ++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID stage and the ID/EX register: decoded ID fields in,
// registered EX fields, hazard hold strobes and the stall counter out.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) ();
    // ID side
    logic              flush;
    logic [REG_W-1:0]  ifIdRs;
    logic [REG_W-1:0]  ifIdRt;
    logic [REG_W-1:0]  ifIdRd;
    logic              idRegWrite;
    logic              idMemRead;
    logic              idMemWrite;
    logic              idMemToReg;
    logic              idAluSrc;
    logic              idRegDst;
    logic [1:0]        idAluOp;
    logic [DATA_W-1:0] idReadData1;
    logic [DATA_W-1:0] idReadData2;
    logic [DATA_W-1:0] idImm;

    // Hold strobes back to PC / IF/ID
    logic              pcWrite;
    logic              ifIdWrite;

    // EX side
    logic              idExValid;
    logic              idExRegWrite;
    logic              idExMemRead;
    logic              idExMemWrite;
    logic              idExMemToReg;
    logic              idExAluSrc;
    logic              idExRegDst;
    logic [1:0]        idExAluOp;
    logic [REG_W-1:0]  idExRs;
    logic [REG_W-1:0]  idExRt;
    logic [REG_W-1:0]  idExRd;
    logic [DATA_W-1:0] idExReadData1;
    logic [DATA_W-1:0] idExReadData2;
    logic [DATA_W-1:0] idExImm;
    logic [CNT_W-1:0]  stallCount;

    modport master (
        output flush, ifIdRs, ifIdRt, ifIdRd,
        output idRegWrite, idMemRead, idMemWrite, idMemToReg, idAluSrc, idRegDst, idAluOp,
        output idReadData1, idReadData2, idImm,
        input  pcWrite, ifIdWrite,
        input  idExValid, idExRegWrite, idExMemRead, idExMemWrite, idExMemToReg,
        input  idExAluSrc, idExRegDst, idExAluOp,
        input  idExRs, idExRt, idExRd, idExReadData1, idExReadData2, idExImm,
        input  stallCount
    );

    modport slave (
        input  flush, ifIdRs, ifIdRt, ifIdRd,
        input  idRegWrite, idMemRead, idMemWrite, idMemToReg, idAluSrc, idRegDst, idAluOp,
        input  idReadData1, idReadData2, idImm,
        output pcWrite, ifIdWrite,
        output idExValid, idExRegWrite, idExMemRead, idExMemWrite, idExMemToReg,
        output idExAluSrc, idExRegDst, idExAluOp,
        output idExRs, idExRt, idExRd, idExReadData1, idExReadData2, idExImm,
        output stallCount
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall or flush, and a saturating stall-cycle counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    ctrl_t             id_ctrl;
    ctrl_t             ex_ctrl;
    logic              ex_valid;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_data1;
    logic [DATA_W-1:0] ex_data2;
    logic [DATA_W-1:0] ex_imm;
    logic [CNT_W-1:0]  stall_cnt;

    logic hazard;
    logic stall;
    logic bubble;

    assign id_ctrl = '{
        reg_write:  bus.idRegWrite,
        mem_read:   bus.idMemRead,
        mem_write:  bus.idMemWrite,
        mem_to_reg: bus.idMemToReg,
        alu_src:    bus.idAluSrc,
        reg_dst:    bus.idRegDst,
        alu_op:     bus.idAluOp
    };

    // Stall protocol: pcWrite/ifIdWrite act as a ready back to the front end.
    // While low, PC and IF/ID hold the ID instruction and this register takes a
    // bubble; the held instruction is accepted on the first edge they read high.
    always_comb begin
        hazard = ex_ctrl.mem_read && (ex_rt != '0) &&
                 ((ex_rt == bus.ifIdRs) || (ex_rt == bus.ifIdRt));
        stall  = hazard && !bus.flush;
        bubble = bus.flush || stall;
    end

    assign bus.pcWrite   = !stall;
    assign bus.ifIdWrite = !stall;

    // Operand fields load even on a bubble; the cleared controls make them inert.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_ctrl  <= '0;
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_data1 <= '0;
            ex_data2 <= '0;
            ex_imm   <= '0;
        end else begin
            ex_ctrl  <= bubble ? ctrl_t'('0) : id_ctrl;
            ex_valid <= !bubble;
            ex_rs    <= bus.ifIdRs;
            ex_rt    <= bus.ifIdRt;
            ex_rd    <= bus.ifIdRd;
            ex_data1 <= bus.idReadData1;
            ex_data2 <= bus.idReadData2;
            ex_imm   <= bus.idImm;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.idExValid     = ex_valid;
    assign bus.idExRegWrite  = ex_ctrl.reg_write;
    assign bus.idExMemRead   = ex_ctrl.mem_read;
    assign bus.idExMemWrite  = ex_ctrl.mem_write;
    assign bus.idExMemToReg  = ex_ctrl.mem_to_reg;
    assign bus.idExAluSrc    = ex_ctrl.alu_src;
    assign bus.idExRegDst    = ex_ctrl.reg_dst;
    assign bus.idExAluOp     = ex_ctrl.alu_op;
    assign bus.idExRs        = ex_rs;
    assign bus.idExRt        = ex_rt;
    assign bus.idExRd        = ex_rd;
    assign bus.idExReadData1 = ex_data1;
    assign bus.idExReadData2 = ex_data2;
    assign bus.idExImm       = ex_imm;
    assign bus.stallCount    = stall_cnt;
endmodule
